// File: rtl/bmi_pkg.sv
// Shared types and constants for the BMI scan reader and its sequential divider.
package bmi_pkg;

  localparam int NUM_USERS = 32;
  localparam int IDX_W     = 5;
  localparam int SCALE     = 100000;
  localparam int DIV_W     = 40;
  localparam int BMI_W     = 16;
  localparam int CNT_W     = 6;

  localparam logic [BMI_W-1:0] BMI_SAT = {BMI_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CALC = 3'd2,
    DIV  = 3'd3,
    OUT  = 3'd4,
    FIN  = 3'd5
  } state_e;

  // Clamp a full-width quotient into the BMI result field.
  function automatic logic [BMI_W-1:0] sat_bmi(input logic [DIV_W-1:0] q);
    logic [BMI_W-1:0] r;
    if (|q[DIV_W-1:BMI_W]) begin
      r = BMI_SAT;
    end else begin
      r = q[BMI_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first; the first bit is
// produced on the start edge so the result is ready DIV_W cycles after start.
module seq_divider
  import bmi_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [31:0]      divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  logic [31:0]      rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      src_rem;
  logic [DIV_W-1:0] src_quo;
  logic [31:0]      src_dvs;
  logic [32:0]      trial;
  logic [31:0]      step_rem;
  logic             step_bit;

  // Divider state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= 32'd0;
      quo_q  <= {DIV_W{1'b0}};
      dvs_q  <= 32'd0;
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // One restoring step; on start the operands come straight from the inputs
  always_comb begin
    if (start) begin
      src_rem = 32'd0;
      src_quo = dividend;
      src_dvs = divisor;
    end else begin
      src_rem = rem_q;
      src_quo = quo_q;
      src_dvs = dvs_q;
    end
    trial = {src_rem, src_quo[DIV_W-1]};
    if (trial >= {1'b0, src_dvs}) begin
      step_rem = trial[31:0] - src_dvs;
      step_bit = 1'b1;
    end else begin
      step_rem = trial[31:0];
      step_bit = 1'b0;
    end
  end

  // Sequencing of the DIV_W steps
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = step_rem;
      quo_d  = {src_quo[DIV_W-2:0], step_bit};
      dvs_d  = divisor;
      cnt_d  = CNT_W'(DIV_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = {src_quo[DIV_W-2:0], step_bit};
      if (cnt_q == CNT_W'(1)) begin
        cnt_d  = {CNT_W{1'b0}};
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/bmi_scan_reader.sv
// Walks every user slot of the height/weight store, computes BMI x10 with a
// shared sequential divider and streams one result per user.
module bmi_scan_reader
  import bmi_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      height_in,
  input  logic [31:0]      weight_in,
  output logic [IDX_W-1:0] user_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_user,
  output logic [BMI_W-1:0] out_bmi,
  output logic             out_err,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] SCALE_V = DIV_W'(SCALE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_USERS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      w_q, w_d;
  logic [IDX_W-1:0] out_user_q, out_user_d;
  logic [BMI_W-1:0] out_bmi_q, out_bmi_d;
  logic             out_err_q, out_err_d;

  logic             div_start;
  logic             div_done;
  logic             unused_div_busy;
  logic [DIV_W-1:0] dividend;
  logic [31:0]      divisor;
  logic [DIV_W-1:0] quotient;
  logic             unused_hi;

  assign unused_hi = ^{height_in[31:16], weight_in[31:16]};
  assign dividend  = DIV_W'(w_q) * SCALE_V;
  assign divisor   = 32'(h_q) * 32'(h_q);

  seq_divider u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (unused_div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= {IDX_W{1'b0}};
      h_q        <= 16'd0;
      w_q        <= 16'd0;
      out_user_q <= {IDX_W{1'b0}};
      out_bmi_q  <= {BMI_W{1'b0}};
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      h_q        <= h_d;
      w_q        <= w_d;
      out_user_q <= out_user_d;
      out_bmi_q  <= out_bmi_d;
      out_err_q  <= out_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = READ;
        else       state_d = IDLE;
      end
      READ: state_d = CALC;
      CALC: begin
        if (h_q == 16'd0) state_d = OUT;
        else              state_d = DIV;
      end
      DIV: begin
        if (div_done) state_d = OUT;
        else          state_d = DIV;
      end
      OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = FIN;
          else                   state_d = READ;
        end else begin
          state_d = OUT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and divider launch; results are held for the whole OUT stall
  always_comb begin
    idx_d      = idx_q;
    h_d        = h_q;
    w_d        = w_q;
    out_user_d = out_user_q;
    out_bmi_d  = out_bmi_q;
    out_err_d  = out_err_q;
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) idx_d = {IDX_W{1'b0}};
        else       idx_d = idx_q;
      end
      READ: begin
        h_d = height_in[15:0];
        w_d = weight_in[15:0];
      end
      CALC: begin
        if (h_q == 16'd0) begin
          out_user_d = idx_q;
          out_bmi_d  = {BMI_W{1'b0}};
          out_err_d  = 1'b1;
        end else begin
          div_start = 1'b1;
        end
      end
      DIV: begin
        if (div_done) begin
          out_user_d = idx_q;
          out_bmi_d  = sat_bmi(quotient);
          out_err_d  = 1'b0;
        end else begin
          out_err_d = out_err_q;
        end
      end
      OUT: begin
        if (out_ready && (idx_q != LAST_IDX)) idx_d = idx_q + IDX_W'(1);
        else                                  idx_d = idx_q;
      end
      FIN:     idx_d = idx_q;
      default: idx_d = idx_q;
    endcase
  end

  assign user_index = idx_q;
  assign out_valid  = (state_q == OUT);
  assign out_user   = out_user_q;
  assign out_bmi    = out_bmi_q;
  assign out_err    = out_err_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_bmi_scan_reader.sv
// Randomized scoreboard bench for bmi_scan_reader: expected results are queued
// at scan start from an arithmetic BMI model and popped by an output monitor.
module tb_bmi_scan_reader;

  localparam int N_USERS = 32;
  localparam int LAT_DIV = 42;
  localparam int LAT_ERR = 2;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] height_in;
  logic [31:0] weight_in;
  logic [4:0]  user_index;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_user;
  logic [15:0] out_bmi;
  logic        out_err;
  logic        busy;
  logic        done;

  logic [31:0] heights [N_USERS];
  logic [31:0] weights [N_USERS];

  assign height_in = heights[user_index];
  assign weight_in = weights[user_index];

  bmi_scan_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .height_in  (height_in),
    .weight_in  (weight_in),
    .user_index (user_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_user   (out_user),
    .out_bmi    (out_bmi),
    .out_err    (out_err),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int user;
    int bmi;
    bit err;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   scans_done = 0;
  bit   rand_mode = 0;
  bit   hold_req = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Plain-arithmetic BMI x10 reference
  function automatic int ref_bmi(input logic [31:0] hw, input logic [31:0] ww);
    longint unsigned h, w, q;
    h = 64'(hw[15:0]);
    w = 64'(ww[15:0]);
    if (h == 0) return 0;
    q = (w * 64'd100000) / (h * h);
    if (q > 64'd65535) return 65535;
    return int'(q);
  endfunction

  task automatic push_scan();
    exp_t e;
    for (int i = 0; i < N_USERS; i++) begin
      e.user = i;
      e.err  = (heights[i][15:0] == 16'd0);
      e.bmi  = ref_bmi(heights[i], weights[i]);
      e.lat  = e.err ? LAT_ERR : LAT_DIV;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_random();
    logic [31:0] r1, r2;
    logic [15:0] h, w;
    for (int i = 0; i < N_USERS; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      case ($urandom_range(0, 9))
        0:       h = 16'd0;
        1:       h = 16'($urandom_range(1, 20));
        2:       h = 16'($urandom_range(0, 65535));
        default: h = 16'($urandom_range(100, 220));
      endcase
      if ($urandom_range(0, 4) == 0) w = 16'($urandom_range(0, 65535));
      else                           w = 16'($urandom_range(30, 150));
      heights[i] = {r1[31:16], h};
      weights[i] = {r2[31:16], w};
    end
  endtask

  task automatic issue_start();
    @(posedge clk);
    #1;
    if (busy) chk("start_while_idle_busy", busy, 0);
    start = 1'b1;
    push_scan();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic rogue_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idx(input int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (busy && user_index == 5'(v)) found = 1'b1;
    end
    if (!found) chk("wait_idx_timeout", 0, v);
  endtask

  task automatic wait_scan(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (scans_done >= target) ok = 1'b1;
    end
    if (!ok) chk("scan_timeout", scans_done, target);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_user_index"}, user_index, 0);
    chk({tag, "_out_user"}, out_user, 0);
    chk({tag, "_out_bmi"}, out_bmi, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready driver: random or tied high, plus one 10-cycle stall on request
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else if (hold_req && out_valid) begin
        out_ready = 1'b0;
        hold_cnt = 9;
        hold_req = 1'b0;
      end else if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor / scoreboard
  initial begin
    int   read_entry, done_due, idle_due;
    bit   prev_valid, hold_active;
    logic [4:0]  s_user;
    logic [15:0] s_bmi;
    logic        s_err;
    exp_t e;
    read_entry = 0; done_due = -1; idle_due = -1;
    prev_valid = 0; hold_active = 0;
    s_user = '0; s_bmi = '0; s_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid = 0; hold_active = 0; done_due = -1; idle_due = -1;
        continue;
      end
      if (start && !busy) read_entry = cyc + 1;
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc - read_entry, exp_q[0].lat);
      end
      if (out_valid && hold_active) begin
        chk("stall_user", out_user, s_user);
        chk("stall_bmi", out_bmi, s_bmi);
        chk("stall_err", out_err, s_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_user", out_user, e.user);
          chk("out_bmi", out_bmi, e.bmi);
          chk("out_err", out_err, e.err);
          if (e.user == N_USERS - 1) done_due = cyc + 1;
          else read_entry = cyc + 1;
        end
      end
      if (cyc == done_due) begin
        chk("done_pulse", done, 1);
        idle_due = cyc + 1;
        done_due = -1;
      end else if (done) begin
        chk("done_unexpected", done, 0);
      end
      if (done) scans_done++;
      if (cyc == idle_due) begin
        chk("idle_busy", busy, 0);
        chk("idle_user_index", user_index, N_USERS - 1);
        idle_due = -1;
      end
      hold_active = out_valid && !out_ready;
      s_user = out_user; s_bmi = out_bmi; s_err = out_err;
      prev_valid = out_valid;
    end
  end

  // Main sequence
  initial begin
    logic [31:0] r;
    start = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < N_USERS; i++) begin
      heights[i] = 32'd0;
      weights[i] = 32'd0;
    end
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    // Scan A: directed users 0..2, random stall, mid-scan store write, ignored start
    fill_random();
    r = $urandom();
    heights[0] = {r[31:16], 16'd170};  weights[0] = {r[15:0], 16'd65};
    heights[1] = {r[15:0], 16'd0};     weights[1] = {r[31:16], 16'd80};
    heights[2] = {r[31:16], 16'd1};    weights[2] = {r[15:0], 16'd1000};
    heights[3] = 32'd175;              weights[3] = 32'd70;
    rand_mode = 1'b1;
    hold_req = 1'b1;
    issue_start();
    wait_idx(3);
    repeat (5) @(posedge clk);
    #1 heights[3] = 32'd120;
    weights[3] = 32'd200;
    rogue_start();
    wait_scan(1);

    // Scan B: ready tied high, reset during DIV of user 5
    rand_mode = 1'b0;
    fill_random();
    issue_start();
    wait_idx(5);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    chk("midreset_pending", exp_q.size(), N_USERS - 5);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Scan C: fresh scan from user 0 with random back-pressure
    rand_mode = 1'b1;
    fill_random();
    issue_start();
    wait_scan(2);
    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
